// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-serial boot loader and instruction memory.
// Receives a framed image (header N, N words of 3 bytes each LSB first,
// and an XOR checksum byte). The image is written into a register-file
// instruction memory. Once the checksum matches, the CPU is released and
// instructions are served combinationally at the CPU fetch address.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 21
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] Addr,
    output logic [INS_W-1:0]  INS,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;

    // Number of valid bits that the third byte of a word contributes.
    localparam int HI_BITS = INS_W - 16;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              armed;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] count;
    logic [7:0]        xor_acc;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [INS_W-1:0]  mem [DEPTH];

    logic              accept;
    logic              hi_bad;
    logic              last_word;
    logic              wr_en;
    logic [INS_W-1:0]  word_new;

    // rx_ready waits one edge after reset release (armed), then follows the state.
    assign rx_ready  = armed & ((state == ST_HDR) | (state == ST_DATA) | (state == ST_CSUM));
    assign accept    = rx_valid & rx_ready;

    // Bits of the third byte above the instruction width must be zero.
    assign hi_bad    = (rx_byte >> HI_BITS) != 8'd0;

    // Modular compare: a header of 0 yields count 0, so the last word is 2^ADDR_W-1.
    assign last_word = (word_idx == (count - ADDR_W'(1)));
    assign word_new  = INS_W'({rx_byte, b1, b0});

    // The CPU sees nothing but zero until a verified image is present.
    assign INS       = cpu_run ? mem[Addr] : '0;

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= ST_HDR;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and write-enable decode.
    always_comb begin
        state_d = state;
        wr_en   = 1'b0;
        case (state)
            ST_HDR: begin
                if (accept) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept && (byte_idx == 2'd2)) begin
                    if (hi_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        wr_en = 1'b1;
                        if (last_word) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_byte == xor_acc) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Frame counters, checksum accumulator and status flags.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            armed        <= 1'b0;
            byte_idx     <= 2'd0;
            word_idx     <= '0;
            count        <= '0;
            xor_acc      <= 8'd0;
            words_loaded <= '0;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if ((state == ST_CSUM) && (state_d == ST_RUN)) begin
                cpu_run <= 1'b1;
            end
            if ((state != ST_ERR) && (state_d == ST_ERR)) begin
                load_err <= 1'b1;
            end
            if (accept && (state == ST_HDR)) begin
                count        <= ADDR_W'(rx_byte);
                xor_acc      <= rx_byte;
                word_idx     <= '0;
                byte_idx     <= 2'd0;
                words_loaded <= '0;
            end
            if (accept && (state == ST_DATA)) begin
                xor_acc <= xor_acc ^ rx_byte;
                if (byte_idx == 2'd2) begin
                    byte_idx <= 2'd0;
                    if (wr_en) begin
                        words_loaded <= word_idx + ADDR_W'(1);
                        if (!last_word) begin
                            word_idx <= word_idx + ADDR_W'(1);
                        end
                    end
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    // Word assembly registers for the first two bytes of each word.
    always_ff @(posedge CLK) begin
        if (accept && (state == ST_DATA)) begin
            if (byte_idx == 2'd0) begin
                b0 <= rx_byte;
            end
            if (byte_idx == 2'd1) begin
                b1 <= rx_byte;
            end
        end
    end

    // Single write port; memory contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[word_idx] <= word_new;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed frames from the test plan plus
// random frames, checked against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int INS_W  = 21;

    logic              CLK;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic [ADDR_W-1:0] Addr;
    logic [INS_W-1:0]  INS;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W-1:0] words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W), .INS_W(INS_W)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready),
        .Addr         (Addr),
        .INS          (INS),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]       fr[$];
    logic [INS_W-1:0] mem_m [256];
    bit               known [256];
    bit               exp_run;
    bit               exp_err;
    int               exp_wl;
    bit               rdy_all;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Interpret the frame in fr: header, words, checksum.
    function automatic void model_frame();
        int n;
        logic [7:0] x, c0, c1, c2;
        exp_err = 0;
        exp_run = 0;
        exp_wl  = 0;
        n = (fr[0] == 8'd0) ? 256 : int'(fr[0]);
        x = fr[0];
        for (int k = 0; k < n; k++) begin
            c0 = fr[1 + 3 * k];
            c1 = fr[2 + 3 * k];
            c2 = fr[3 + 3 * k];
            x  = x ^ c0 ^ c1 ^ c2;
            if (c2 >= 8'd32) begin
                exp_err = 1;
                return;
            end
            mem_m[k] = (INS_W'(c2) << 16) | (INS_W'(c1) << 8) | INS_W'(c0);
            known[k] = 1;
            exp_wl   = (k + 1) % 256;
        end
        if (fr[1 + 3 * n] == x) exp_run = 1;
        else exp_err = 1;
    endfunction

    // Build a frame of n words (0 => 256); bad_word >= 0 plants an oversize top byte.
    task automatic build_frame(input int n, input int bad_word, input bit bad_csum);
        int nn;
        logic [7:0] x, v;
        fr.delete();
        v = 8'(n);
        fr.push_back(v);
        x  = v;
        nn = (n == 0) ? 256 : n;
        for (int k = 0; k < nn; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (j < 2) v = 8'($urandom_range(0, 255));
                else if (k == bad_word) v = 8'($urandom_range(32, 255));
                else v = 8'($urandom_range(0, 31));
                fr.push_back(v);
                x = x ^ v;
            end
        end
        fr.push_back(bad_csum ? (x ^ 8'h01) : x);
    endtask

    // Send fr[lo..hi]; starts and ends at a falling edge.
    task automatic send_range(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            rx_valid = 1'b1;
            rx_byte  = fr[i];
            rdy_all  = rdy_all & rx_ready;
            @(negedge CLK);
            if (gap) begin
                rx_valid = 1'b0;
                rx_byte  = 8'($urandom);
                @(negedge CLK);
                @(negedge CLK);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic verify(input string tag);
        chk({tag, ".cpu_run"}, 32'(cpu_run), 32'(exp_run));
        chk({tag, ".load_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(exp_wl));
        chk({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
        if (exp_run) begin
            for (int a = 0; a < 256; a++) begin
                if (known[a]) begin
                    Addr = 8'(a);
                    #1;
                    chk({tag, ".INS"}, 32'(INS), 32'(mem_m[a]));
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                Addr = 8'($urandom);
                #1;
                chk({tag, ".INS_zero"}, 32'(INS), 32'd0);
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        Addr     = '0;
        for (int a = 0; a < 256; a++) known[a] = 0;
        #1;
        chk("rst.rx_ready", 32'(rx_ready), 32'd0);
        chk("rst.cpu_run", 32'(cpu_run), 32'd0);
        chk("rst.load_err", 32'(load_err), 32'd0);
        chk("rst.words_loaded", 32'(words_loaded), 32'd0);
        chk("rst.INS", 32'(INS), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("rel.rx_ready_low", 32'(rx_ready), 32'd0);
        @(negedge CLK);
        chk("rel.rx_ready_high", 32'(rx_ready), 32'd1);

        // Directed frame with rx_valid held high
        fr = '{8'h02, 8'h05, 8'h00, 8'h0C, 8'h07, 8'h08, 8'h0C, 8'h08};
        model_frame();
        rdy_all = 1;
        send_range(0, 6, 0);
        chk("d1.cpu_run_before", 32'(cpu_run), 32'd0);
        send_range(7, 7, 0);
        chk("d1.rx_ready_all", 32'(rdy_all), 32'd1);
        chk("d1.cpu_run_after", 32'(cpu_run), 32'd1);
        Addr = 8'd0;
        #1;
        chk("d1.INS0", 32'(INS), 32'h0C0005);
        Addr = 8'd1;
        #1;
        chk("d1.INS1", 32'(INS), 32'h0C0807);
        rx_valid = 1'b1;
        rx_byte  = 8'hAA;
        @(negedge CLK);
        rx_valid = 1'b0;
        verify("d1");

        // Bad checksum
        do_reset();
        fr[7] = 8'h09;
        model_frame();
        send_range(0, 7, 0);
        verify("d2");

        // Oversize top byte on the only word
        do_reset();
        fr = '{8'h01, 8'h05, 8'h00, 8'h2C, 8'h00};
        model_frame();
        send_range(0, 3, 0);
        verify("d3");

        // Same 2-word frame, gap-free then with rx_valid toggling
        do_reset();
        build_frame(2, -1, 0);
        model_frame();
        send_range(0, fr.size() - 1, 0);
        verify("g0");
        do_reset();
        for (int a = 0; a < 256; a++) known[a] = 0;
        model_frame();
        send_range(0, 3, 1);
        chk("g1.mid_words", 32'(words_loaded), 32'd1);
        Addr = 8'd0;
        #1;
        chk("g1.mid_INS_zero", 32'(INS), 32'd0);
        @(negedge CLK);
        send_range(4, fr.size() - 1, 1);
        verify("g1");

        // 256-word frame, word k = k
        do_reset();
        fr.delete();
        fr.push_back(8'h00);
        for (int k = 0; k < 256; k++) begin
            fr.push_back(8'(k));
            fr.push_back(8'h00);
            fr.push_back(8'h00);
        end
        fr.push_back(8'h00);  // 0 ^ (0^1^...^255) = 0
        model_frame();
        send_range(0, 765, 0);
        chk("f256.words_255", 32'(words_loaded), 32'd255);
        chk("f256.ready_255", 32'(rx_ready), 32'd1);
        send_range(766, 768, 0);
        chk("f256.ready_csum", 32'(rx_ready), 32'd1);
        chk("f256.no_run_yet", 32'(cpu_run), 32'd0);
        send_range(769, 769, 0);
        Addr = 8'd255;
        #1;
        chk("f256.INS255", 32'(INS), 32'h0000FF);
        @(negedge CLK);
        verify("f256");

        // Random frames
        for (int t = 0; t < 8; t++) begin
            int n, kind;
            do_reset();
            n    = $urandom_range(1, 12);
            kind = $urandom_range(0, 2);
            build_frame(n, (kind == 1) ? $urandom_range(0, n - 1) : -1, kind == 2);
            model_frame();
            send_range(0, fr.size() - 1, $urandom_range(0, 1) == 1);
            verify("rnd");
        end

        // Asynchronous reset mid-frame
        do_reset();
        build_frame(3, -1, 0);
        send_range(0, 3, 0);
        chk("ar.words_before", 32'(words_loaded), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.rx_ready", 32'(rx_ready), 32'd0);
        chk("ar.words_loaded", 32'(words_loaded), 32'd0);
        chk("ar.load_err", 32'(load_err), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        model_frame();
        send_range(0, fr.size() - 1, 0);
        verify("ar_fresh");

        // Asynchronous reset out of RUN
        Addr = 8'd0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_run.cpu_run", 32'(cpu_run), 32'd0);
        chk("ar_run.INS", 32'(INS), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        build_frame(4, -1, 0);
        model_frame();
        send_range(0, fr.size() - 1, 0);
        verify("ar_run_fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
